hazard_forward_unit: RTL and testbench

- Parametrised successor to the pipeline forwarding logic: computes bypass selects for NUM_SRC operands across FWD_DEPTH writeback stages.
- Adds load-use stall generation, a register scoreboard for variable-latency (mul/div) writebacks with RAW/WAW stalls, and saturating stall counters.
- Sits between the ID/EX pipeline registers and the hazard-control inputs of the IF/ID and ID/EX registers.

---
 rtl/hazard_forward_unit_pkg.sv | 24 ++
 rtl/hazard_forward_unit_if.sv | 53 +++++
 rtl/hazard_forward_unit_reg_scoreboard.sv | 51 +++++
 rtl/hazard_forward_unit.sv | 141 ++++++++++++++
 tb/tb_hazard_forward_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and defaults for the pipeline hazard/forwarding unit.
package hazard_forward_unit_pkg;

  localparam int unsigned NUM_SRC_DEF   = 3;
  localparam int unsigned FWD_DEPTH_DEF = 2;
  localparam int unsigned REG_AW_DEF    = 5;
  localparam int unsigned NUM_REGS_DEF  = 32;
  localparam int unsigned CNT_W_DEF     = 32;

  // Forward select encoding: 0 = register file, FWD_STAGE0 + k = bypass stage k.
  localparam int unsigned FWD_NONE   = 0;
  localparam int unsigned FWD_STAGE0 = 1;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    LONG_WAIT  = 2'd2
  } hazard_state_e;

  function automatic int unsigned fwd_code(input int unsigned stage);
    return stage + FWD_STAGE0;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Bundle of ID/EX/bypass inputs and hazard-control outputs of the forwarding unit.
interface hazard_forward_unit_if
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned NUM_SRC   = NUM_SRC_DEF,
  parameter int unsigned FWD_DEPTH = FWD_DEPTH_DEF,
  parameter int unsigned REG_AW    = REG_AW_DEF,
  parameter int unsigned SEL_W     = $clog2(FWD_DEPTH + 1),
  parameter int unsigned CNT_W     = CNT_W_DEF
) ();

  logic                         id_valid;
  logic [NUM_SRC-1:0]           id_src_en;
  logic [NUM_SRC*REG_AW-1:0]    id_src_addr;
  logic                         id_rd_we;
  logic [REG_AW-1:0]            id_rd_addr;
  logic                         id_is_long;

  logic                         ex_valid;
  logic [NUM_SRC-1:0]           ex_src_en;
  logic [NUM_SRC*REG_AW-1:0]    ex_src_addr;
  logic                         ex_rd_we;
  logic [REG_AW-1:0]            ex_rd_addr;
  logic                         ex_is_load;
  logic                         ex_is_long;

  logic [FWD_DEPTH-1:0]         stage_we;
  logic [FWD_DEPTH*REG_AW-1:0]  stage_rd;
  logic                         long_done;
  logic [REG_AW-1:0]            long_rd;
  logic                         flush;

  logic [NUM_SRC*SEL_W-1:0]     fwd_sel;
  logic                         stall_id;
  logic                         bubble_ex;
  logic [CNT_W-1:0]             load_stall_cnt;
  logic [CNT_W-1:0]             long_stall_cnt;

  modport master (
    output id_valid, id_src_en, id_src_addr, id_rd_we, id_rd_addr, id_is_long,
    output ex_valid, ex_src_en, ex_src_addr, ex_rd_we, ex_rd_addr, ex_is_load, ex_is_long,
    output stage_we, stage_rd, long_done, long_rd, flush,
    input  fwd_sel, stall_id, bubble_ex, load_stall_cnt, long_stall_cnt
  );

  modport slave (
    input  id_valid, id_src_en, id_src_addr, id_rd_we, id_rd_addr, id_is_long,
    input  ex_valid, ex_src_en, ex_src_addr, ex_rd_we, ex_rd_addr, ex_is_load, ex_is_long,
    input  stage_we, stage_rd, long_done, long_rd, flush,
    output fwd_sel, stall_id, bubble_ex, load_stall_cnt, long_stall_cnt
  );

endinterface

// File: rtl/hazard_forward_unit_reg_scoreboard.sv
// Pending-writeback bit per architectural register for variable-latency units,
// with combinational lookup of several register addresses.
module reg_scoreboard
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned REG_AW   = REG_AW_DEF,
  parameter int unsigned NUM_LK   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en_i,
  input  logic [REG_AW-1:0]        set_addr_i,
  input  logic                     clr_en_i,
  input  logic [REG_AW-1:0]        clr_addr_i,
  input  logic                     flush_i,
  input  logic [NUM_LK*REG_AW-1:0] lk_addr_i,
  output logic [NUM_LK-1:0]        lk_hit_o,
  output logic                     any_o
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;

  // Set is applied after clear so a same-register set/clear leaves the bit pending.
  always_comb begin
    pend_d = pend_q;
    if (flush_i) begin
      pend_d = '0;
    end else begin
      if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
      if (set_en_i) pend_d[set_addr_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  always_comb begin
    lk_hit_o = '0;
    for (int l = 0; l < int'(NUM_LK); l++) begin
      lk_hit_o[l] = pend_q[lk_addr_i[l*REG_AW +: REG_AW]];
    end
  end

  assign any_o = |pend_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand bypass selection, load-use and long-latency hazard detection, stall-cause
// tracking and saturating stall counters for the ID/EX boundary.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned NUM_SRC   = NUM_SRC_DEF,
  parameter int unsigned FWD_DEPTH = FWD_DEPTH_DEF,
  parameter int unsigned REG_AW    = REG_AW_DEF,
  parameter int unsigned NUM_REGS  = NUM_REGS_DEF,
  parameter int unsigned SEL_W     = $clog2(FWD_DEPTH + 1),
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input logic                  clk,
  input logic                  rst,
  hazard_forward_unit_if.slave hz
);

  localparam int unsigned NUM_LK = NUM_SRC + 1;

  logic [NUM_SRC*SEL_W-1:0] fwd_sel_c;
  logic                     load_haz_c;
  logic                     long_haz_c;
  logic                     stall_c;
  logic                     sb_set_c;
  logic                     sb_any;
  logic [NUM_LK-1:0]        lk_hit;
  logic [CNT_W-1:0]         load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0]         long_cnt_q, long_cnt_d;
  hazard_state_e            state_q;

  // Per-operand bypass priority: youngest matching stage wins, x0 never forwarded.
  for (genvar gi = 0; gi < int'(NUM_SRC); gi++) begin : g_fwd
    logic [REG_AW-1:0] addr;
    logic [SEL_W-1:0]  sel;

    assign addr = hz.ex_src_addr[gi*REG_AW +: REG_AW];

    always_comb begin
      sel = SEL_W'(FWD_NONE);
      for (int k = int'(FWD_DEPTH) - 1; k >= 0; k--) begin
        if (hz.stage_we[k] && (hz.stage_rd[k*REG_AW +: REG_AW] == addr)) begin
          sel = SEL_W'(fwd_code(unsigned'(k)));
        end
      end
      if (rst || !hz.ex_valid || !hz.ex_src_en[gi] || (addr == '0)) begin
        sel = SEL_W'(FWD_NONE);
      end
    end

    assign fwd_sel_c[gi*SEL_W +: SEL_W] = sel;
  end

  always_comb begin
    load_haz_c = 1'b0;
    if (hz.id_valid && hz.ex_valid && hz.ex_is_load && hz.ex_rd_we && (hz.ex_rd_addr != '0)) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (hz.id_src_en[i] && (hz.id_src_addr[i*REG_AW +: REG_AW] == hz.ex_rd_addr)) begin
          load_haz_c = 1'b1;
        end
      end
    end
  end

  assign sb_set_c = hz.ex_valid && hz.ex_is_long && hz.ex_rd_we &&
                    (hz.ex_rd_addr != '0) && !hz.flush;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW),
    .NUM_LK   (NUM_LK)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (sb_set_c),
    .set_addr_i (hz.ex_rd_addr),
    .clr_en_i   (hz.long_done),
    .clr_addr_i (hz.long_rd),
    .flush_i    (hz.flush),
    .lk_addr_i  ({hz.id_rd_addr, hz.id_src_addr}),
    .lk_hit_o   (lk_hit),
    .any_o      (sb_any)
  );

  // RAW on a pending source, WAW on the destination, or a second long op while one is outstanding.
  always_comb begin
    long_haz_c = 1'b0;
    if (hz.id_valid) begin
      if (|(hz.id_src_en & lk_hit[NUM_SRC-1:0])) long_haz_c = 1'b1;
      if (hz.id_rd_we && lk_hit[NUM_SRC])        long_haz_c = 1'b1;
      if (hz.id_is_long && sb_any)               long_haz_c = 1'b1;
    end
  end

  assign stall_c = !rst && !hz.flush && (load_haz_c || long_haz_c);

  always_comb begin
    load_cnt_d = load_cnt_q;
    long_cnt_d = long_cnt_q;
    if (stall_c) begin
      if (long_haz_c) begin
        if (!(&long_cnt_q)) long_cnt_d = long_cnt_q + CNT_W'(1);
      end else begin
        if (!(&load_cnt_q)) load_cnt_d = load_cnt_q + CNT_W'(1);
      end
    end
  end

  // Cause-tracking state and counters; flush returns to RUN regardless of hazards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      load_cnt_q <= '0;
      long_cnt_q <= '0;
    end else begin
      load_cnt_q <= load_cnt_d;
      long_cnt_q <= long_cnt_d;
      if (hz.flush) begin
        state_q <= RUN;
      end else begin
        unique case (state_q)
          RUN: begin
            if (long_haz_c)      state_q <= LONG_WAIT;
            else if (load_haz_c) state_q <= LOAD_STALL;
          end
          LOAD_STALL: state_q <= RUN;
          LONG_WAIT: begin
            if (!long_haz_c) state_q <= RUN;
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign hz.fwd_sel        = fwd_sel_c;
  assign hz.stall_id       = stall_c;
  assign hz.bubble_ex      = stall_c;
  assign hz.load_stall_cnt = rst ? '0 : load_cnt_q;
  assign hz.long_stall_cnt = rst ? '0 : long_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Table-driven and sequence checks of hazard_forward_unit against a cycle model.
module tb_hazard_forward_unit;
  import hazard_forward_unit_pkg::*;

  logic clk;
  logic rst;

  hazard_forward_unit_if hz ();

  hazard_forward_unit dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_src_en;
    logic [14:0] id_src_addr;
    logic        id_rd_we;
    logic [4:0]  id_rd_addr;
    logic        id_is_long;
    logic        ex_valid;
    logic [2:0]  ex_src_en;
    logic [14:0] ex_src_addr;
    logic        ex_rd_we;
    logic [4:0]  ex_rd_addr;
    logic        ex_is_load;
    logic        ex_is_long;
    logic [1:0]  stage_we;
    logic [9:0]  stage_rd;
    logic        long_done;
    logic [4:0]  long_rd;
    logic        flush;
  } in_t;

  typedef struct {
    logic [5:0]    fwd;
    logic          stall;
    logic [31:0]   lcnt;
    logic [31:0]   gcnt;
    hazard_state_e st;
    string         name;
  } exp_t;

  typedef struct {
    in_t        in;
    logic [5:0] fwd;
    logic       stall;
    string      name;
  } row_t;

  exp_t          exp_q[$];
  row_t          tbl[16];
  int            errs   = 0;
  int            checks = 0;

  logic [31:0]   m_pend = '0;
  logic [31:0]   m_load = '0;
  logic [31:0]   m_long = '0;
  hazard_state_e m_state = RUN;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  function automatic in_t fwd_case(input logic exv, input logic [2:0] en,
                                   input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                   input logic [1:0] we, input logic [4:0] r0, input logic [4:0] r1);
    in_t x = '0;
    x.ex_valid    = exv;
    x.ex_src_en   = en;
    x.ex_src_addr = {a2, a1, a0};
    x.stage_we    = we;
    x.stage_rd    = {r1, r0};
    return x;
  endfunction

  function automatic in_t lu_case(input logic idv, input logic [2:0] en,
                                  input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                                  input logic exv, input logic ld, input logic we, input logic [4:0] rd);
    in_t x = '0;
    x.id_valid    = idv;
    x.id_src_en   = en;
    x.id_src_addr = {s2, s1, s0};
    x.ex_valid    = exv;
    x.ex_is_load  = ld;
    x.ex_rd_we    = we;
    x.ex_rd_addr  = rd;
    return x;
  endfunction

  function automatic in_t ex_long(input logic [4:0] rd);
    in_t x = '0;
    x.ex_valid   = 1'b1;
    x.ex_is_long = 1'b1;
    x.ex_rd_we   = 1'b1;
    x.ex_rd_addr = rd;
    return x;
  endfunction

  function automatic in_t id_use(input logic [4:0] s0);
    in_t x = '0;
    x.id_valid    = 1'b1;
    x.id_src_en   = 3'b001;
    x.id_src_addr = {10'd0, s0};
    return x;
  endfunction

  // Expected combinational outputs from the model state held before the coming edge.
  function automatic void model_eval(input in_t x, output logic [5:0] f, output logic s,
                                     output logic ld, output logic lh);
    logic [4:0] a;
    logic [4:0] ia;
    f  = '0;
    ld = 1'b0;
    lh = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a  = x.ex_src_addr[i*5 +: 5];
      ia = x.id_src_addr[i*5 +: 5];
      if (x.ex_valid && x.ex_src_en[i] && a != 5'd0) begin
        if (x.stage_we[0] && x.stage_rd[4:0] == a)      f[i*2 +: 2] = 2'd1;
        else if (x.stage_we[1] && x.stage_rd[9:5] == a) f[i*2 +: 2] = 2'd2;
      end
      if (x.id_valid && x.id_src_en[i]) begin
        if (x.ex_valid && x.ex_is_load && x.ex_rd_we && x.ex_rd_addr != 5'd0 && ia == x.ex_rd_addr) ld = 1'b1;
        if (m_pend[ia]) lh = 1'b1;
      end
    end
    if (x.id_valid && x.id_rd_we && m_pend[x.id_rd_addr]) lh = 1'b1;
    if (x.id_valid && x.id_is_long && m_pend != 32'd0)     lh = 1'b1;
    s = !x.rst && !x.flush && (ld || lh);
    if (x.rst) f = '0;
  endfunction

  function automatic void model_update(input in_t x, input logic s, input logic ld, input logic lh);
    if (x.rst) begin
      m_pend  = '0;
      m_load  = '0;
      m_long  = '0;
      m_state = RUN;
      return;
    end
    if (s) begin
      if (lh) begin
        if (m_long != 32'hFFFF_FFFF) m_long = m_long + 32'd1;
      end else begin
        if (m_load != 32'hFFFF_FFFF) m_load = m_load + 32'd1;
      end
    end
    if (x.flush) begin
      m_state = RUN;
      m_pend  = '0;
    end else begin
      case (m_state)
        RUN:        if (lh) m_state = LONG_WAIT; else if (ld) m_state = LOAD_STALL;
        LOAD_STALL: m_state = RUN;
        default:    if (!lh) m_state = RUN;
      endcase
      if (x.long_done) m_pend[x.long_rd] = 1'b0;
      if (x.ex_valid && x.ex_is_long && x.ex_rd_we && x.ex_rd_addr != 5'd0) m_pend[x.ex_rd_addr] = 1'b1;
    end
  endfunction

  task automatic drive(input in_t x);
    rst            = x.rst;
    hz.id_valid    = x.id_valid;
    hz.id_src_en   = x.id_src_en;
    hz.id_src_addr = x.id_src_addr;
    hz.id_rd_we    = x.id_rd_we;
    hz.id_rd_addr  = x.id_rd_addr;
    hz.id_is_long  = x.id_is_long;
    hz.ex_valid    = x.ex_valid;
    hz.ex_src_en   = x.ex_src_en;
    hz.ex_src_addr = x.ex_src_addr;
    hz.ex_rd_we    = x.ex_rd_we;
    hz.ex_rd_addr  = x.ex_rd_addr;
    hz.ex_is_load  = x.ex_is_load;
    hz.ex_is_long  = x.ex_is_long;
    hz.stage_we    = x.stage_we;
    hz.stage_rd    = x.stage_rd;
    hz.long_done   = x.long_done;
    hz.long_rd     = x.long_rd;
    hz.flush       = x.flush;
  endtask

  task automatic check_out();
    exp_t e;
    e = exp_q.pop_front();
    chk({e.name, ".fwd_sel"},   32'(hz.fwd_sel),        32'(e.fwd));
    chk({e.name, ".stall_id"},  32'(hz.stall_id),       32'(e.stall));
    chk({e.name, ".bubble_ex"}, 32'(hz.bubble_ex),      32'(e.stall));
    chk({e.name, ".load_cnt"},  hz.load_stall_cnt,      e.lcnt);
    chk({e.name, ".long_cnt"},  hz.long_stall_cnt,      e.gcnt);
    if (!rst) chk({e.name, ".state"}, 32'(dut.state_q), 32'(e.st));
  endtask

  // One clock: drive after the edge, push the expectation, compare at the falling edge.
  task automatic step(input in_t x, input string name, input logic use_tbl,
                      input logic [5:0] tfwd, input logic tstall);
    exp_t       e;
    logic [5:0] f;
    logic       s, ld, lh;
    @(posedge clk);
    #1;
    drive(x);
    model_eval(x, f, s, ld, lh);
    e.fwd   = use_tbl ? tfwd : f;
    e.stall = use_tbl ? tstall : s;
    e.lcnt  = x.rst ? 32'd0 : m_load;
    e.gcnt  = x.rst ? 32'd0 : m_long;
    e.st    = m_state;
    e.name  = name;
    exp_q.push_back(e);
    @(negedge clk);
    check_out();
    model_update(x, s, ld, lh);
  endtask

  task automatic mstep(input in_t x, input string name);
    step(x, name, 1'b0, 6'd0, 1'b0);
  endtask

  initial begin
    in_t x;

    tbl[0]  = '{fwd_case(1, 3'b001, 5, 0, 0, 2'b11, 5, 5), 6'b000001, 1'b0, "fwd_youngest"};
    tbl[1]  = '{fwd_case(1, 3'b001, 0, 0, 0, 2'b11, 0, 0), 6'b000000, 1'b0, "fwd_x0"};
    tbl[2]  = '{fwd_case(1, 3'b001, 5, 0, 0, 2'b10, 5, 5), 6'b000010, 1'b0, "fwd_oldest_only"};
    tbl[3]  = '{fwd_case(1, 3'b110, 5, 5, 6, 2'b11, 6, 5), 6'b011000, 1'b0, "fwd_mixed_en"};
    tbl[4]  = '{fwd_case(0, 3'b001, 5, 0, 0, 2'b11, 5, 5), 6'b000000, 1'b0, "fwd_ex_invalid"};
    tbl[5]  = '{fwd_case(1, 3'b111, 7, 7, 7, 2'b11, 8, 9), 6'b000000, 1'b0, "fwd_no_match"};
    tbl[6]  = '{fwd_case(1, 3'b111, 3, 4, 3, 2'b11, 3, 4), 6'b011001, 1'b0, "fwd_all_ops"};
    tbl[7]  = '{fwd_case(1, 3'b001, 5, 0, 0, 2'b00, 5, 5), 6'b000000, 1'b0, "fwd_no_we"};
    tbl[8]  = '{lu_case(1, 3'b010, 0, 7, 0, 1, 1, 1, 7),   6'b000000, 1'b1, "lu_hit"};
    tbl[9]  = '{lu_case(1, 3'b010, 0, 7, 0, 1, 0, 1, 7),   6'b000000, 1'b0, "lu_not_load"};
    tbl[10] = '{lu_case(1, 3'b010, 0, 7, 0, 1, 1, 0, 7),   6'b000000, 1'b0, "lu_no_we"};
    tbl[11] = '{lu_case(1, 3'b010, 0, 0, 0, 1, 1, 1, 0),   6'b000000, 1'b0, "lu_x0"};
    tbl[12] = '{lu_case(0, 3'b010, 0, 7, 0, 1, 1, 1, 7),   6'b000000, 1'b0, "lu_id_invalid"};
    tbl[13] = '{lu_case(1, 3'b101, 7, 7, 2, 1, 1, 1, 7),   6'b000000, 1'b1, "lu_src0"};
    tbl[14] = '{lu_case(1, 3'b010, 0, 8, 0, 1, 1, 1, 7),   6'b000000, 1'b0, "lu_diff_reg"};
    tbl[15] = '{lu_case(1, 3'b010, 0, 7, 0, 0, 1, 1, 7),   6'b000000, 1'b0, "lu_ex_invalid"};

    x = '0;
    x.rst = 1'b1;
    drive(x);

    x = lu_case(1, 3'b010, 0, 7, 0, 1, 1, 1, 7);
    x.ex_src_en = 3'b001; x.ex_src_addr[4:0] = 5'd5; x.stage_we = 2'b01; x.stage_rd[4:0] = 5'd5;
    x.rst = 1'b1;
    step(x, "reset", 1'b1, 6'd0, 1'b0);

    // Load-use: one stall cycle, bubble clears EX, back to RUN.
    step(lu_case(1, 3'b010, 0, 7, 0, 1, 1, 1, 7), "lu_seq_stall", 1'b1, 6'd0, 1'b1);
    step(lu_case(1, 3'b010, 0, 7, 0, 0, 0, 0, 0), "lu_seq_bubble", 1'b1, 6'd0, 1'b0);
    chk("lu_seq_state_load", 32'(dut.state_q), 32'(LOAD_STALL));
    mstep('0, "lu_seq_run");
    chk("lu_seq_cnt", hz.load_stall_cnt, 32'd1);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].in, tbl[i].name, 1'b1, tbl[i].fwd, tbl[i].stall);
    end

    x = '0; x.rst = 1'b1;
    mstep(x, "reset2");

    // Long RAW: stall through the long_done cycle.
    mstep(ex_long(9), "raw_issue");
    for (int c = 0; c < 5; c++) begin
      x = id_use(9);
      if (c == 4) begin x.long_done = 1'b1; x.long_rd = 5'd9; end
      mstep(x, "raw_wait");
    end
    mstep(id_use(9), "raw_release");
    chk("raw_release_stall", 32'(hz.stall_id), 32'd0);
    chk("raw_long_cnt", hz.long_stall_cnt, 32'd5);

    // WAW on a pending destination.
    mstep(ex_long(3), "waw_issue");
    for (int c = 0; c < 3; c++) begin
      x = '0; x.id_valid = 1'b1; x.id_rd_we = 1'b1; x.id_rd_addr = 5'd3;
      if (c == 2) begin x.long_done = 1'b1; x.long_rd = 5'd3; end
      mstep(x, "waw_wait");
    end
    x = '0; x.id_valid = 1'b1; x.id_rd_we = 1'b1; x.id_rd_addr = 5'd3;
    mstep(x, "waw_release");

    // Second long op while one is outstanding.
    mstep(ex_long(4), "struct_issue");
    for (int c = 0; c < 3; c++) begin
      x = '0; x.id_valid = 1'b1; x.id_is_long = 1'b1; x.id_rd_we = 1'b1; x.id_rd_addr = 5'd10;
      if (c == 1) begin x.long_done = 1'b1; x.long_rd = 5'd4; end
      mstep(x, "struct_wait");
    end

    // Same-register set and clear in one cycle leaves the bit pending.
    x = ex_long(12); x.long_done = 1'b1; x.long_rd = 5'd12;
    mstep(x, "set_wins");
    mstep(id_use(12), "set_wins_stall");
    chk("set_wins_stall_id", 32'(hz.stall_id), 32'd1);
    x = id_use(12); x.long_done = 1'b1; x.long_rd = 5'd12;
    mstep(x, "set_wins_done");
    mstep(id_use(12), "set_wins_release");

    // Flush during LONG_WAIT.
    mstep(ex_long(9), "flush_issue");
    mstep(id_use(9), "flush_wait0");
    mstep(id_use(9), "flush_wait1");
    chk("flush_state_long", 32'(dut.state_q), 32'(LONG_WAIT));
    x = id_use(9); x.flush = 1'b1;
    x.ex_valid = 1'b1; x.ex_is_long = 1'b1; x.ex_rd_we = 1'b1; x.ex_rd_addr = 5'd11;
    mstep(x, "flush_cycle");
    x = id_use(9); x.id_src_en = 3'b011; x.id_src_addr[9:5] = 5'd11;
    mstep(x, "flush_after");
    chk("flush_after_stall", 32'(hz.stall_id), 32'd0);
    chk("flush_state_run", 32'(dut.state_q), 32'(RUN));

    // Reset in the middle of a load stall.
    mstep(lu_case(1, 3'b010, 0, 7, 0, 1, 1, 1, 7), "rst_mid_stall");
    x = lu_case(1, 3'b010, 0, 7, 0, 1, 1, 1, 7);
    x.ex_src_en = 3'b001; x.ex_src_addr[4:0] = 5'd5; x.stage_we = 2'b01; x.stage_rd[4:0] = 5'd5;
    x.rst = 1'b1;
    mstep(x, "rst_asserted");
    mstep(lu_case(1, 3'b010, 0, 7, 0, 0, 0, 0, 0), "rst_released");
    chk("rst_load_cnt", hz.load_stall_cnt, 32'd0);
    chk("rst_long_cnt", hz.long_stall_cnt, 32'd0);

    // Counter saturation near all-ones.
    mstep(ex_long(20), "sat_issue");
    force dut.long_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.long_cnt_q;
    m_long = 32'hFFFF_FFFD;
    for (int c = 0; c < 3; c++) begin
      x = id_use(20);
      if (c == 2) begin x.long_done = 1'b1; x.long_rd = 5'd20; end
      mstep(x, "sat_wait");
    end
    mstep('0, "sat_idle");
    chk("sat_long_cnt", hz.long_stall_cnt, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
